rr_mux4_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 39 +++
 rtl/mux4_w.sv | 27 ++
 rtl/rr_mux4_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
//   arb_state_t : FSM state encoding (ST_IDLE: no owner, ST_GRANT: one owner)
//   arb_dbg_t   : debug view of the arbiter FSM (state and priority pointer)
//   NUM_SRC     : number of requesters
//   rr_next     : next index in round-robin order (wraps 3 -> 0)
//   rr_pick     : first set bit of a request mask, searching from a pointer
package arb_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    arb_state_t  state;
    logic [1:0]  ptr;
  } arb_dbg_t;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  // Returns {found, index}. Offsets are scanned from the farthest to the
  // nearest so that the last hit, i.e. the nearest to ptr, is kept.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4_w.sv
// Parametric-width 4:1 multiplexer.
//   d0..d3 : WIDTH-bit source data
//   sel    : binary source index
//   y      : d[sel]
module mux4_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit output channel between four
// requesters, with a hold limit so a busy owner cannot starve the others.
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   req        : request per source, bit i = source i
//   d0..d3     : source data
//   gnt        : registered one-hot grant, zero when idle
//   sel        : registered binary owner index (held while idle)
//   busy       : registered, high while a grant is active
//   y          : d[sel] when busy, else 0 (combinational from sel/busy)
//   dbg        : FSM state and priority pointer
//
// Handshake: a request is a level. The owner keeps gnt for as long as its
// req stays high, unless others are waiting and it has used MAX_HOLD
// consecutive cycles; dropping req releases the grant at the next edge.
module rr_mux4_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [WIDTH-1:0] y,
  output arb_dbg_t         dbg
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  arb_state_t  state, state_n;
  logic [1:0]  ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [3:0]  gnt_n;
  logic [1:0]  sel_n;
  logic        busy_n;

  logic [3:0]  others;
  logic        owner_req;
  logic [2:0]  pick_any;
  logic [2:0]  pick_oth;
  logic [WIDTH-1:0] mux_y;

  // The current owner is excluded from a handoff search, so it can never
  // win back the grant while somebody else is asking.
  assign others    = req & ~gnt;
  assign owner_req = |(req & gnt);
  assign pick_any  = rr_pick(req, ptr);
  assign pick_oth  = rr_pick(others, ptr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= 2'd0;
      hold_cnt <= '0;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    gnt_n   = gnt;
    sel_n   = sel;
    busy_n  = busy;
    case (state)
      ST_IDLE: begin
        if (pick_any[2]) begin
          state_n = ST_GRANT;
          gnt_n   = 4'b0001 << pick_any[1:0];
          sel_n   = pick_any[1:0];
          busy_n  = 1'b1;
          hold_n  = '0;
          ptr_n   = rr_next(pick_any[1:0]);
        end
      end
      ST_GRANT: begin
        // hold_cnt saturates at HOLD_MAX, so "not at max" means "below max".
        if (owner_req && ((hold_cnt != HOLD_MAX) || (others == 4'b0000))) begin
          if (hold_cnt != HOLD_MAX) hold_n = hold_cnt + 1'b1;
        end else if (pick_oth[2]) begin
          gnt_n   = 4'b0001 << pick_oth[1:0];
          sel_n   = pick_oth[1:0];
          hold_n  = '0;
          ptr_n   = rr_next(pick_oth[1:0]);
        end else begin
          state_n = ST_IDLE;
          gnt_n   = 4'b0000;
          busy_n  = 1'b0;
          hold_n  = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = 4'b0000;
        busy_n  = 1'b0;
      end
    endcase
  end

  mux4_w #(.WIDTH(WIDTH)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (sel),
    .y   (mux_y)
  );

  assign y = busy ? mux_y : '0;

  assign dbg.state = state;
  assign dbg.ptr   = ptr;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed testbench for rr_mux4_arbiter (WIDTH=8, MAX_HOLD=4).
module tb_rr_mux4_arbiter;
  import arb_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         busy;
  logic [W-1:0] y;
  arb_dbg_t     dbg;

  int n_vec;
  int n_err;

  rr_mux4_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .y     (y),
    .dbg   (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    d0 = 8'h10; d1 = 8'h11; d2 = 8'h12; d3 = 8'h13;
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || y !== 8'h00 || sel !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b busy=%b sel=%0d y=%h, want 0000 0 0 00",
               gnt, busy, sel, y);
    end
    n_vec++;
    if (dbg.state !== ST_IDLE || dbg.ptr !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: state=%0d ptr=%0d, want 0 0", dbg.state, dbg.ptr);
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || sel !== 2'd0 || y !== 8'h10) begin
      n_err++;
      $display("FAIL reset_release: gnt=%b busy=%b sel=%0d y=%h, want 0001 1 0 10",
               gnt, busy, sel, y);
    end
  endtask

  task automatic test_single();
    do_reset();
    d2  = 8'hA5;
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1 || y !== 8'hA5) begin
        n_err++;
        $display("FAIL single_hold[%0d]: gnt=%b sel=%0d busy=%b y=%h, want 0100 2 1 a5",
                 i, gnt, sel, busy, y);
      end
    end
    // y follows the data combinationally, no edge needed.
    d2 = 8'h3C;
    #1;
    n_vec++;
    if (y !== 8'h3C) begin
      n_err++;
      $display("FAIL y_comb: y=%h, want 3c", y);
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] dv [4];
    logic [3:0]   exp_g;
    int           idx;
    dv[0] = 8'hC0; dv[1] = 8'hC1; dv[2] = 8'hC2; dv[3] = 8'hC3;
    d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step();
      idx   = (i / 4) % 4;
      exp_g = 4'b0001 << idx;
      n_vec++;
      if (gnt !== exp_g || y !== dv[idx] || busy !== 1'b1) begin
        n_err++;
        $display("FAIL contention[%0d]: gnt=%b y=%h busy=%b, want %b %h 1",
                 i, gnt, y, busy, exp_g, dv[idx]);
      end
    end
  endtask

  task automatic test_handoff_and_wrap();
    d0 = 8'h50; d3 = 8'h53;
    do_reset();
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (gnt !== 4'b0001) begin
        n_err++;
        $display("FAIL handoff_owner[%0d]: gnt=%b, want 0001", i, gnt);
      end
    end
    req = 4'b1000;
    step();
    n_vec++;
    if (gnt !== 4'b1000 || busy !== 1'b1 || sel !== 2'd3 || y !== 8'h53) begin
      n_err++;
      $display("FAIL handoff_next: gnt=%b busy=%b sel=%0d y=%h, want 1000 1 3 53",
               gnt, busy, sel, y);
    end
    // Source 3 finishes; arbiter idles with sel held.
    req = 4'b0000;
    step();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd3 || y !== 8'h00) begin
      n_err++;
      $display("FAIL release_idle: gnt=%b busy=%b sel=%0d y=%h, want 0000 0 3 00",
               gnt, busy, sel, y);
    end
    // ptr wrapped to 0, so source 0 beats source 3.
    req = 4'b1001;
    step();
    n_vec++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || y !== 8'h50) begin
      n_err++;
      $display("FAIL wrap_priority: gnt=%b sel=%0d y=%h, want 0001 0 50", gnt, sel, y);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0010;
    step();
    step();
    n_vec++;
    if (gnt !== 4'b0010 || dbg.ptr !== 2'd2) begin
      n_err++;
      $display("FAIL midreset_pre: gnt=%b ptr=%0d, want 0010 2", gnt, dbg.ptr);
    end
    rst_n = 1'b0;
    step();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || dbg.ptr !== 2'd0 || dbg.state !== ST_IDLE) begin
      n_err++;
      $display("FAIL midreset_drop: gnt=%b busy=%b ptr=%0d state=%0d, want 0000 0 0 0",
               gnt, busy, dbg.ptr, dbg.state);
    end
    rst_n = 1'b1;
    req   = 4'b0011;
    step();
    n_vec++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_err++;
      $display("FAIL midreset_regrant: gnt=%b sel=%0d, want 0001 0", gnt, sel);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_handoff_and_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
